// File: rtl/adder_sum_accumulator.sv
// Frame accumulator behind the 4-bit ripple adder stage.
// Sums COUNT carry-extended results and hands the total downstream.
module adder_sum_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_cout,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_overflow,
  output logic [3:0]       out_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(COUNT);

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic             ovf, ovf_n;
  logic [3:0]       cnt, cnt_n;
  logic [ACC_W:0]   sum;
  logic             take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      ovf   <= ovf_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    sum     = {1'b0, acc}
            + {{(ACC_W-4){1'b0}}, in_cout, in_sum};
    take    = in_valid && (state != DONE);
    state_n = state;
    acc_n   = acc;
    ovf_n   = ovf;
    cnt_n   = cnt;
    if (clear) begin
      // abort wins over any accept or handshake this cycle
      state_n = IDLE;
      acc_n   = '0;
      ovf_n   = 1'b0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (take) begin
            acc_n   = sum[ACC_W-1:0];
            ovf_n   = ovf | sum[ACC_W];
            cnt_n   = cnt + 4'd1;
            state_n = (cnt + 4'd1 == LAST)
                    ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_n = IDLE;
            acc_n   = '0;
            ovf_n   = 1'b0;
            cnt_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign in_ready     = (state != DONE);
  assign out_valid    = (state == DONE);
  assign out_total    = acc;
  assign out_overflow = ovf;
  assign out_count    = cnt;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Scoreboard bench for adder_sum_accumulator.
// Three instances: defaults, ACC_W=6, COUNT=1.
module tb_adder_sum_accumulator;

  localparam int CNTS[3] = '{4, 4, 1};
  localparam int ACCW[3] = '{8, 6, 8};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] iv = '0;
  logic [2:0] clr = '0;
  logic [2:0] ordy = '0;
  logic [2:0][4:0] op = '0;
  logic [2:0] irdy, ovld, oovf;
  logic [2:0][3:0] ocnt;
  logic [2:0][15:0] otot;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int g;
    int tot;
    int ovf;
    int cnt;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [ACCW[g]-1:0] t;
    adder_sum_accumulator #(
      .COUNT(CNTS[g]),
      .ACC_W(ACCW[g])
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (iv[g]),
      .in_ready    (irdy[g]),
      .in_sum      (op[g][3:0]),
      .in_cout     (op[g][4]),
      .clear       (clr[g]),
      .out_valid   (ovld[g]),
      .out_ready   (ordy[g]),
      .out_total   (t),
      .out_overflow(oovf[g]),
      .out_count   (ocnt[g])
    );
    assign otot[g] = 16'(t);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int g, input int tot,
                      input int ovf, input int cnt);
    exp_t e;
    e.g = g;
    e.tot = tot;
    e.ovf = ovf;
    e.cnt = cnt;
    sbq.push_back(e);
  endtask

  // holds in_valid until accepted; leaves it asserted
  task automatic send(input int g, input int v);
    logic acc;
    int n;
    op[g] = 5'(v);
    iv[g] = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      acc = irdy[g];
      tick();
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int g);
    iv[g] = 1'b0;
  endtask

  task automatic chk_rst(input int g);
    chk("rst_in_ready", 32'(irdy[g]), 1);
    chk("rst_out_valid", 32'(ovld[g]), 0);
    chk("rst_total", 32'(otot[g]), 0);
    chk("rst_ovf", 32'(oovf[g]), 0);
    chk("rst_count", 32'(ocnt[g]), 0);
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      for (int g = 0; g < 3; g++) begin
        if (ovld[g] === 1'b1 && ordy[g] === 1'b1) begin
          if (sbq.size() == 0) begin
            chk("sb_unexpected", 1, 0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_dut", g, e.g);
            chk("sb_total", 32'(otot[g]), e.tot);
            chk("sb_ovf", 32'(oovf[g]), e.ovf);
            chk("sb_count", 32'(ocnt[g]), e.cnt);
          end
        end
      end
    end
  end

  initial begin
    int t0;
    // reset pulsed mid-cycle, checked before any edge
    #3 rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) chk_rst(g);
    #8 rst = 1'b0;
    tick();
    chk_rst(0);

    // basic frame, back to back
    ordy[0] = 1'b1;
    push(0, 61, 0, 4);
    t0 = $time;
    send(0, 8);
    send(0, 22);
    chk("cnt_mid", 32'(ocnt[0]), 2);
    send(0, 16);
    chk("valid_early", 32'(ovld[0]), 0);
    send(0, 15);
    idle(0);
    chk("b2b_cycles", 32'(($time - t0) / 10), 4);
    chk("valid_lat", 32'(ovld[0]), 1);
    chk("ready_done", 32'(irdy[0]), 0);
    tick();
    chk("ready_back", 32'(irdy[0]), 1);
    chk("valid_drop", 32'(ovld[0]), 0);
    chk("cnt_clr", 32'(ocnt[0]), 0);

    // backpressure
    ordy[0] = 1'b0;
    push(0, 61, 0, 4);
    send(0, 8);
    send(0, 22);
    send(0, 16);
    send(0, 15);
    op[0] = 5'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(ovld[0]), 1);
      chk("bp_ready", 32'(irdy[0]), 0);
      chk("bp_total", 32'(otot[0]), 61);
      chk("bp_count", 32'(ocnt[0]), 4);
    end
    ordy[0] = 1'b1;
    tick();
    chk("hs_ready", 32'(irdy[0]), 1);
    chk("hs_count", 32'(ocnt[0]), 0);
    tick();
    idle(0);
    chk("f2_count", 32'(ocnt[0]), 1);
    chk("f2_total", 32'(otot[0]), 5);
    push(0, 11, 0, 4);
    send(0, 1);
    send(0, 2);
    send(0, 3);
    idle(0);
    tick();

    // overflow with ACC_W=6
    ordy[1] = 1'b1;
    push(1, 60, 1, 4);
    for (int i = 0; i < 4; i++) send(1, 31);
    idle(1);
    chk("ovf_flag", 32'(oovf[1]), 1);
    tick();
    push(1, 4, 0, 4);
    for (int i = 0; i < 4; i++) send(1, 1);
    idle(1);
    tick();

    // clear mid-frame, with a colliding input
    send(0, 8);
    send(0, 8);
    idle(0);
    clr[0] = 1'b1;
    tick();
    chk("clr_count", 32'(ocnt[0]), 0);
    chk("clr_total", 32'(otot[0]), 0);
    op[0] = 5'd7;
    iv[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    idle(0);
    chk("clr_drop", 32'(ocnt[0]), 0);
    push(0, 10, 0, 4);
    send(0, 1);
    send(0, 2);
    send(0, 3);
    send(0, 4);
    idle(0);
    tick();

    // clear in DONE discards the result
    ordy[0] = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 9);
    idle(0);
    tick();
    chk("clr_done_v", 32'(ovld[0]), 1);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("clr_done_v0", 32'(ovld[0]), 0);
    chk("clr_done_t", 32'(otot[0]), 0);
    chk("clr_done_c", 32'(ocnt[0]), 0);
    ordy[0] = 1'b1;

    // reset after 3 accepts
    send(0, 1);
    send(0, 1);
    send(0, 1);
    idle(0);
    chk("pre_rst_cnt", 32'(ocnt[0]), 3);
    #2 rst = 1'b1;
    #1 chk_rst(0);
    tick();
    rst = 1'b0;
    tick();
    chk_rst(0);

    // COUNT=1
    ordy[2] = 1'b1;
    push(2, 22, 0, 1);
    send(2, 22);
    idle(2);
    chk("c1_valid", 32'(ovld[2]), 1);
    chk("c1_total", 32'(otot[2]), 22);
    tick();
    push(2, 16, 0, 1);
    send(2, 16);
    idle(2);
    chk("c1_valid2", 32'(ovld[2]), 1);
    tick();
    tick();

    chk("sb_empty", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
